rv32_pipeline_ctrl: RTL



---
 rtl/rv32_pipeline_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rv32_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pipeline_ctrl
// Brief    : Hazard, forwarding and flush control for the 5-stage rv32i pipe,
//            plus instret / stall-cycle debug counters.
//            Define PIPE_FWD_EN for EX/MEM and MEM/WB forwarding; without it
//            every RAW dependency stalls until the producer has left WB.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_redirect,
    input  logic                  ext_stall,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      instret,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] c_fwd_rf  = 2'b00;
    localparam logic [1:0] c_fwd_mem = 2'b01;
    localparam logic [1:0] c_fwd_wb  = 2'b10;

    logic                  r_ex_valid, r_ex_reg_write, r_ex_mem_read;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic                  r_mem_valid, r_mem_reg_write, r_mem_mem_read;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_valid, r_wb_reg_write, r_wb_mem_read;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [CNT_W-1:0]      r_instret, r_stall_cnt;
    logic                  w_hazard;

    // x0 is hardwired to zero, so it can never carry a dependency
    function automatic logic f_match(input logic v, input logic rw,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] r);
        return v & rw & (rd != '0) & (rd == r);
    endfunction

    function automatic logic f_id_dep(input logic v, input logic rw,
                                      input logic [REG_ADDR_W-1:0] rd);
        return (id_use_rs1 & f_match(v, rw, rd, id_rs1)) |
               (id_use_rs2 & f_match(v, rw, rd, id_rs2));
    endfunction

`ifdef PIPE_FWD_EN
    // A load result is only available after MEM, so the EX/MEM path skips loads
    always_comb begin
        w_hazard = id_valid & r_ex_mem_read &
                   f_id_dep(r_ex_valid, r_ex_reg_write, r_ex_rd);
        fwd_a = c_fwd_rf;
        fwd_b = c_fwd_rf;
        if (f_match(r_mem_valid, r_mem_reg_write, r_mem_rd, r_ex_rs1) & !r_mem_mem_read)
            fwd_a = c_fwd_mem;
        else if (f_match(r_wb_valid, r_wb_reg_write, r_wb_rd, r_ex_rs1))
            fwd_a = c_fwd_wb;
        if (f_match(r_mem_valid, r_mem_reg_write, r_mem_rd, r_ex_rs2) & !r_mem_mem_read)
            fwd_b = c_fwd_mem;
        else if (f_match(r_wb_valid, r_wb_reg_write, r_wb_rd, r_ex_rs2))
            fwd_b = c_fwd_wb;
    end

    logic w_unused;
    assign w_unused = r_wb_mem_read;
`else
    // The regfile has no write-through, so the producer must leave WB first
    always_comb begin
        w_hazard = id_valid & (f_id_dep(r_ex_valid,  r_ex_reg_write,  r_ex_rd)  |
                               f_id_dep(r_mem_valid, r_mem_reg_write, r_mem_rd) |
                               f_id_dep(r_wb_valid,  r_wb_reg_write,  r_wb_rd));
        fwd_a = c_fwd_rf;
        fwd_b = c_fwd_rf;
    end

    logic w_unused;
    assign w_unused = ^{r_ex_rs1, r_ex_rs2, r_ex_mem_read, r_mem_mem_read, r_wb_mem_read};
`endif

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_mem_rd        <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_read   <= 1'b0;
            r_wb_rd         <= '0;
            r_instret       <= '0;
            r_stall_cnt     <= '0;
        end else if (!ext_stall) begin
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_read   <= r_mem_mem_read;
            r_wb_rd         <= r_mem_rd;
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            r_mem_rd        <= r_ex_rd;
            if (idex_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_rd        <= '0;
                r_ex_rs1       <= '0;
                r_ex_rs2       <= '0;
            end else begin
                r_ex_valid     <= id_valid;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
                r_ex_rd        <= id_rd;
                r_ex_rs1       <= id_rs1;
                r_ex_rs2       <= id_rs2;
            end
            r_instret   <= r_instret + {{(CNT_W-1){1'b0}}, r_wb_valid};
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, (w_hazard & !ex_redirect)};
        end
    end

    assign instret   = r_instret;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
